// File: rtl/pll_hdmi_pkg.sv
// Shared types, widths and video mode table for the HDMI pixel-clock PLL supervisor.
// The mode table assumes a 27 MHz reference and an 1188 MHz VCO.
package pll_hdmi_pkg;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_WAIT_LOCK,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    localparam int MODE_COUNT = 3;
    localparam int MODE_W = $clog2(MODE_COUNT);
    localparam int TBL_W = 10;

    localparam int REF_FREQ_HZ = 27_000_000;
    localparam int VCO_FREQ_HZ = 1_188_000_000;

    // VCO = REF * RATIOF / RATIOI; pixel clock = VCO / RATIO0
    localparam logic [TBL_W-1:0] MODE_RATIOI [MODE_COUNT] = '{10'd1, 10'd1, 10'd1};
    localparam logic [TBL_W-1:0] MODE_RATIOF [MODE_COUNT] = '{10'd44, 10'd44, 10'd44};
    localparam logic [TBL_W-1:0] MODE_RATIO0 [MODE_COUNT] = '{10'd44, 10'd16, 10'd8};

endpackage

// File: rtl/pll_hdmi_reconfig_lock_sync.sv
// Two-flop synchronizer for the raw PLL lock plus a consecutive-high run counter.
// lock_stable flags the cycle in which lock_s completes LOCK_STABLE high cycles in a row.
module pll_lock_sync #(
    parameter int LOCK_STABLE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lock_raw,
    input  logic clear,
    output logic lock_s,
    output logic lock_stable
);

    localparam int SW = $clog2(LOCK_STABLE) + 1;
    localparam logic [SW-1:0] RUN_TOP = SW'(LOCK_STABLE - 1);

    logic          meta;
    logic [SW-1:0] run;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            lock_s <= 1'b0;
            run    <= '0;
        end else begin
            meta   <= lock_raw;
            lock_s <= meta;
            if (clear || !lock_s) begin
                run <= '0;
            end else if (run != RUN_TOP) begin
                run <= run + SW'(1);
            end
        end
    end

    assign lock_stable = lock_s && (run == RUN_TOP);

endmodule

// File: rtl/pll_hdmi_reconfig.sv
// HDMI pixel PLL supervisor: mode selection, dynamic ratio drive, reset sequencing,
// debounced lock qualification with timeout and bounded retries.
module pll_hdmi_reconfig
    import pll_hdmi_pkg::*;
#(
    parameter int NUM_MODES    = MODE_COUNT,
    parameter int DEFAULT_MODE = 1,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 8,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int MAX_RETRY    = 3,
    parameter int DIV_W        = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode_req_valid,
    input  logic [MODE_W-1:0] mode_req,
    output logic              mode_req_ready,
    input  logic              pll_lock_i,
    output logic              pll_rst_o,
    output logic              pll_rstodiv_o,
    output logic [DIV_W-1:0]  ratio_i_o,
    output logic [DIV_W-1:0]  ratio_f_o,
    output logic [DIV_W-1:0]  ratio0_o,
    output logic [MODE_W-1:0] cur_mode,
    output logic              locked,
    output logic              busy,
    output logic              fail,
    output logic              req_err,
    output logic [1:0]        retry_cnt
);

    localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX = (MAX_AB > LOCK_STABLE) ? MAX_AB : LOCK_STABLE;
    localparam int CNT_W = $clog2(CNT_MAX) + 1;

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic [1:0]        retry;
    logic [1:0]        retry_n;
    logic [1:0]        retry_inc;
    logic [MODE_W-1:0] mode;
    logic [MODE_W-1:0] mode_n;
    logic              load;
    logic              err_n;
    logic              accept;
    logic              in_range;
    logic              sync_clr;
    logic              lock_s;
    logic              lock_stable;

    assign sync_clr = (state != ST_WAIT_LOCK);

    pll_lock_sync #(
        .LOCK_STABLE(LOCK_STABLE)
    ) u_lock_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .lock_raw   (pll_lock_i),
        .clear      (sync_clr),
        .lock_s     (lock_s),
        .lock_stable(lock_stable)
    );

    assign mode_req_ready = (state == ST_LOCKED) || (state == ST_FAIL);
    assign accept         = mode_req_valid && mode_req_ready;
    assign in_range       = int'(mode_req) < NUM_MODES;
    assign retry_inc      = retry + 2'd1;

    always_comb begin
        state_n = state;
        cnt_n   = (&cnt) ? cnt : cnt + CNT_W'(1);
        retry_n = retry;
        mode_n  = mode;
        load    = 1'b0;
        err_n   = 1'b0;
        unique case (state)
            ST_RESET: begin
                if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                    state_n = ST_WAIT_LOCK;
                    cnt_n   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_stable) begin
                    state_n = ST_LOCKED;
                    retry_n = '0;
                end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    retry_n = retry_inc;
                    cnt_n   = '0;
                    state_n = (retry_inc == 2'(MAX_RETRY)) ? ST_FAIL : ST_RESET;
                end
            end
            ST_LOCKED: begin
                if (!lock_s) begin
                    state_n = ST_RESET;
                    cnt_n   = '0;
                    retry_n = '0;
                end
            end
            ST_FAIL: begin
                state_n = ST_FAIL;
            end
            default: begin
                state_n = ST_RESET;
                cnt_n   = '0;
            end
        endcase
        // An accepted request overrides any lock-loss transition in the same cycle
        if (accept) begin
            if (in_range) begin
                state_n = ST_RESET;
                cnt_n   = '0;
                retry_n = '0;
                mode_n  = mode_req;
                load    = 1'b1;
            end else begin
                err_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_RESET;
            cnt       <= '0;
            retry     <= '0;
            mode      <= MODE_W'(DEFAULT_MODE);
            req_err   <= 1'b0;
            ratio_i_o <= DIV_W'(MODE_RATIOI[DEFAULT_MODE]);
            ratio_f_o <= DIV_W'(MODE_RATIOF[DEFAULT_MODE]);
            ratio0_o  <= DIV_W'(MODE_RATIO0[DEFAULT_MODE]);
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            retry   <= retry_n;
            mode    <= mode_n;
            req_err <= err_n;
            if (load) begin
                ratio_i_o <= DIV_W'(MODE_RATIOI[mode_req]);
                ratio_f_o <= DIV_W'(MODE_RATIOF[mode_req]);
                ratio0_o  <= DIV_W'(MODE_RATIO0[mode_req]);
            end
        end
    end

    assign pll_rst_o     = (state == ST_RESET) || (state == ST_FAIL);
    assign pll_rstodiv_o = pll_rst_o;
    assign cur_mode      = mode;
    assign retry_cnt     = retry;
    assign locked        = (state == ST_LOCKED);
    assign busy          = (state == ST_RESET) || (state == ST_WAIT_LOCK);
    assign fail          = (state == ST_FAIL);

endmodule

// File: tb/tb_pll_hdmi_reconfig.sv
// Directed bench for pll_hdmi_reconfig: bring-up, mode change, lock glitch,
// bad requests, retry exhaustion and mid-sequence reset.
module tb_pll_hdmi_reconfig;

    logic       clk;
    logic       rst_n;
    logic       mode_req_valid;
    logic [1:0] mode_req;
    logic       mode_req_ready;
    logic       pll_lock_i;
    logic       pll_rst_o;
    logic       pll_rstodiv_o;
    logic [9:0] ratio_i_o;
    logic [9:0] ratio_f_o;
    logic [9:0] ratio0_o;
    logic [1:0] cur_mode;
    logic       locked;
    logic       busy;
    logic       fail;
    logic       req_err;
    logic [1:0] retry_cnt;

    int checks = 0;
    int passed = 0;

    pll_hdmi_reconfig #(
        .NUM_MODES   (3),
        .DEFAULT_MODE(1),
        .RST_CYCLES  (16),
        .LOCK_STABLE (8),
        .LOCK_TIMEOUT(1000),
        .MAX_RETRY   (3),
        .DIV_W       (10)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mode_req_valid(mode_req_valid),
        .mode_req      (mode_req),
        .mode_req_ready(mode_req_ready),
        .pll_lock_i    (pll_lock_i),
        .pll_rst_o     (pll_rst_o),
        .pll_rstodiv_o (pll_rstodiv_o),
        .ratio_i_o     (ratio_i_o),
        .ratio_f_o     (ratio_f_o),
        .ratio0_o      (ratio0_o),
        .cur_mode      (cur_mode),
        .locked        (locked),
        .busy          (busy),
        .fail          (fail),
        .req_err       (req_err),
        .retry_cnt     (retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        step(3);
        checks++; if (pll_rst_o !== 1'b1) $display("FAIL reset_pll_rst: got %b want 1", pll_rst_o); else passed++;
        checks++; if (pll_rstodiv_o !== 1'b1) $display("FAIL reset_rstodiv: got %b want 1", pll_rstodiv_o); else passed++;
        checks++; if (ratio0_o !== 10'd16) $display("FAIL reset_ratio0: got %0d want 16", ratio0_o); else passed++;
        checks++; if (ratio_i_o !== 10'd1) $display("FAIL reset_ratioi: got %0d want 1", ratio_i_o); else passed++;
        checks++; if (ratio_f_o !== 10'd44) $display("FAIL reset_ratiof: got %0d want 44", ratio_f_o); else passed++;
        checks++; if (cur_mode !== 2'd1) $display("FAIL reset_mode: got %0d want 1", cur_mode); else passed++;
        checks++; if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy); else passed++;
        checks++; if (fail !== 1'b0) $display("FAIL reset_fail: got %b want 0", fail); else passed++;
        checks++; if (req_err !== 1'b0) $display("FAIL reset_req_err: got %b want 0", req_err); else passed++;
        checks++; if (retry_cnt !== 2'd0) $display("FAIL reset_retry: got %0d want 0", retry_cnt); else passed++;
        checks++; if (mode_req_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", mode_req_ready); else passed++;
    endtask

    task automatic test_bringup();
        rst_n = 1'b1;
        step(15);
        checks++; if (pll_rst_o !== 1'b1) $display("FAIL bringup_rst_hold: got %b want 1", pll_rst_o); else passed++;
        checks++; if (ratio0_o !== 10'd16) $display("FAIL bringup_ratio0: got %0d want 16", ratio0_o); else passed++;
        step();
        checks++; if (pll_rst_o !== 1'b0) $display("FAIL bringup_rst_fall: got %b want 0", pll_rst_o); else passed++;
        checks++; if (pll_rstodiv_o !== 1'b0) $display("FAIL bringup_rstodiv_fall: got %b want 0", pll_rstodiv_o); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL bringup_busy_wait: got %b want 1", busy); else passed++;
        step(4);
        pll_lock_i = 1'b1;
        step(9);
        checks++; if (locked !== 1'b0) $display("FAIL bringup_locked_early: got %b want 0", locked); else passed++;
        step();
        checks++; if (locked !== 1'b1) $display("FAIL bringup_locked: got %b want 1", locked); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL bringup_busy: got %b want 0", busy); else passed++;
        checks++; if (mode_req_ready !== 1'b1) $display("FAIL bringup_ready: got %b want 1", mode_req_ready); else passed++;
    endtask

    task automatic test_mode_change();
        mode_req_valid = 1'b1;
        mode_req = 2'd2;
        step();
        mode_req_valid = 1'b0;
        pll_lock_i = 1'b0;
        checks++; if (ratio0_o !== 10'd8) $display("FAIL mode_ratio0: got %0d want 8", ratio0_o); else passed++;
        checks++; if (pll_rst_o !== 1'b1) $display("FAIL mode_pll_rst: got %b want 1", pll_rst_o); else passed++;
        checks++; if (cur_mode !== 2'd2) $display("FAIL mode_cur: got %0d want 2", cur_mode); else passed++;
        checks++; if (locked !== 1'b0) $display("FAIL mode_locked_drop: got %b want 0", locked); else passed++;
        checks++; if (mode_req_ready !== 1'b0) $display("FAIL mode_ready: got %b want 0", mode_req_ready); else passed++;
        step(15);
        checks++; if (pll_rst_o !== 1'b1) $display("FAIL mode_rst_hold: got %b want 1", pll_rst_o); else passed++;
        step();
        checks++; if (pll_rst_o !== 1'b0) $display("FAIL mode_rst_fall: got %b want 0", pll_rst_o); else passed++;
        pll_lock_i = 1'b1;
        step(9);
        checks++; if (locked !== 1'b0) $display("FAIL mode_locked_early: got %b want 0", locked); else passed++;
        step();
        checks++; if (locked !== 1'b1) $display("FAIL mode_locked: got %b want 1", locked); else passed++;
        checks++; if (ratio0_o !== 10'd8) $display("FAIL mode_ratio0_kept: got %0d want 8", ratio0_o); else passed++;
    endtask

    task automatic test_glitch();
        pll_lock_i = 1'b0;
        step();
        pll_lock_i = 1'b1;
        step();
        checks++; if (locked !== 1'b1) $display("FAIL glitch_locked_hold: got %b want 1", locked); else passed++;
        step();
        checks++; if (locked !== 1'b0) $display("FAIL glitch_locked_fall: got %b want 0", locked); else passed++;
        checks++; if (pll_rst_o !== 1'b1) $display("FAIL glitch_pll_rst: got %b want 1", pll_rst_o); else passed++;
        checks++; if (cur_mode !== 2'd2) $display("FAIL glitch_mode: got %0d want 2", cur_mode); else passed++;
        checks++; if (ratio0_o !== 10'd8) $display("FAIL glitch_ratio0: got %0d want 8", ratio0_o); else passed++;
        pll_lock_i = 1'b0;
        step(16);
        checks++; if (pll_rst_o !== 1'b0) $display("FAIL glitch_rst_fall: got %b want 0", pll_rst_o); else passed++;
        pll_lock_i = 1'b1;
        step(7);
        pll_lock_i = 1'b0;
        step(14);
        checks++; if (locked !== 1'b0) $display("FAIL short_pulse_locked: got %b want 0", locked); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL short_pulse_busy: got %b want 1", busy); else passed++;
        checks++; if (pll_rst_o !== 1'b0) $display("FAIL short_pulse_rst: got %b want 0", pll_rst_o); else passed++;
        pll_lock_i = 1'b1;
        step(9);
        checks++; if (locked !== 1'b0) $display("FAIL relock_early: got %b want 0", locked); else passed++;
        step();
        checks++; if (locked !== 1'b1) $display("FAIL relock: got %b want 1", locked); else passed++;
    endtask

    task automatic test_req_err();
        mode_req_valid = 1'b1;
        mode_req = 2'd3;
        step();
        mode_req_valid = 1'b0;
        checks++; if (req_err !== 1'b1) $display("FAIL req_err_pulse: got %b want 1", req_err); else passed++;
        checks++; if (locked !== 1'b1) $display("FAIL req_err_locked: got %b want 1", locked); else passed++;
        checks++; if (cur_mode !== 2'd2) $display("FAIL req_err_mode: got %0d want 2", cur_mode); else passed++;
        checks++; if (ratio0_o !== 10'd8) $display("FAIL req_err_ratio0: got %0d want 8", ratio0_o); else passed++;
        step();
        checks++; if (req_err !== 1'b0) $display("FAIL req_err_one_cycle: got %b want 0", req_err); else passed++;
        checks++; if (locked !== 1'b1) $display("FAIL req_err_locked2: got %b want 1", locked); else passed++;
        pll_lock_i = 1'b0;
        step();
        checks++; if (locked !== 1'b1) $display("FAIL coinc_locked: got %b want 1", locked); else passed++;
        step();
        mode_req_valid = 1'b1;
        mode_req = 2'd0;
        step();
        mode_req_valid = 1'b0;
        checks++; if (cur_mode !== 2'd0) $display("FAIL coinc_mode: got %0d want 0", cur_mode); else passed++;
        checks++; if (ratio0_o !== 10'd44) $display("FAIL coinc_ratio0: got %0d want 44", ratio0_o); else passed++;
        checks++; if (locked !== 1'b0) $display("FAIL coinc_locked_drop: got %b want 0", locked); else passed++;
        checks++; if (pll_rst_o !== 1'b1) $display("FAIL coinc_pll_rst: got %b want 1", pll_rst_o); else passed++;
        step(16);
        pll_lock_i = 1'b1;
        step(10);
        checks++; if (locked !== 1'b1) $display("FAIL coinc_relock: got %b want 1", locked); else passed++;
        checks++; if (cur_mode !== 2'd0) $display("FAIL coinc_mode_kept: got %0d want 0", cur_mode); else passed++;
    endtask

    task automatic test_fail();
        mode_req_valid = 1'b1;
        mode_req = 2'd1;
        pll_lock_i = 1'b0;
        step();
        mode_req_valid = 1'b0;
        checks++; if (cur_mode !== 2'd1) $display("FAIL fail_mode: got %0d want 1", cur_mode); else passed++;
        checks++; if (ratio0_o !== 10'd16) $display("FAIL fail_ratio0: got %0d want 16", ratio0_o); else passed++;
        step(1015);
        checks++; if (retry_cnt !== 2'd0) $display("FAIL attempt1_retry: got %0d want 0", retry_cnt); else passed++;
        checks++; if (pll_rst_o !== 1'b0) $display("FAIL attempt1_rst: got %b want 0", pll_rst_o); else passed++;
        step();
        checks++; if (retry_cnt !== 2'd1) $display("FAIL timeout1_retry: got %0d want 1", retry_cnt); else passed++;
        checks++; if (pll_rst_o !== 1'b1) $display("FAIL timeout1_rst: got %b want 1", pll_rst_o); else passed++;
        step(1015);
        checks++; if (retry_cnt !== 2'd1) $display("FAIL attempt2_retry: got %0d want 1", retry_cnt); else passed++;
        step();
        checks++; if (retry_cnt !== 2'd2) $display("FAIL timeout2_retry: got %0d want 2", retry_cnt); else passed++;
        step(1015);
        checks++; if (fail !== 1'b0) $display("FAIL attempt3_fail: got %b want 0", fail); else passed++;
        checks++; if (retry_cnt !== 2'd2) $display("FAIL attempt3_retry: got %0d want 2", retry_cnt); else passed++;
        step();
        checks++; if (fail !== 1'b1) $display("FAIL exhausted_fail: got %b want 1", fail); else passed++;
        checks++; if (retry_cnt !== 2'd3) $display("FAIL exhausted_retry: got %0d want 3", retry_cnt); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL exhausted_busy: got %b want 0", busy); else passed++;
        checks++; if (mode_req_ready !== 1'b1) $display("FAIL exhausted_ready: got %b want 1", mode_req_ready); else passed++;
        step(20);
        checks++; if (fail !== 1'b1) $display("FAIL fail_held: got %b want 1", fail); else passed++;
        checks++; if (pll_rst_o !== 1'b1) $display("FAIL fail_rst_held: got %b want 1", pll_rst_o); else passed++;
        mode_req_valid = 1'b1;
        mode_req = 2'd0;
        step();
        mode_req_valid = 1'b0;
        checks++; if (fail !== 1'b0) $display("FAIL recover_fail: got %b want 0", fail); else passed++;
        checks++; if (retry_cnt !== 2'd0) $display("FAIL recover_retry: got %0d want 0", retry_cnt); else passed++;
        checks++; if (cur_mode !== 2'd0) $display("FAIL recover_mode: got %0d want 0", cur_mode); else passed++;
        checks++; if (ratio0_o !== 10'd44) $display("FAIL recover_ratio0: got %0d want 44", ratio0_o); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL recover_busy: got %b want 1", busy); else passed++;
    endtask

    task automatic test_mid_reset();
        step(1016);
        checks++; if (retry_cnt !== 2'd1) $display("FAIL mid_retry_pre: got %0d want 1", retry_cnt); else passed++;
        step(20);
        checks++; if (pll_rst_o !== 1'b0) $display("FAIL mid_in_wait: got %b want 0", pll_rst_o); else passed++;
        rst_n = 1'b0;
        step();
        checks++; if (pll_rst_o !== 1'b1) $display("FAIL mid_pll_rst: got %b want 1", pll_rst_o); else passed++;
        checks++; if (pll_rstodiv_o !== 1'b1) $display("FAIL mid_rstodiv: got %b want 1", pll_rstodiv_o); else passed++;
        checks++; if (cur_mode !== 2'd1) $display("FAIL mid_mode: got %0d want 1", cur_mode); else passed++;
        checks++; if (ratio0_o !== 10'd16) $display("FAIL mid_ratio0: got %0d want 16", ratio0_o); else passed++;
        checks++; if (retry_cnt !== 2'd0) $display("FAIL mid_retry: got %0d want 0", retry_cnt); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", busy); else passed++;
        checks++; if (locked !== 1'b0) $display("FAIL mid_locked: got %b want 0", locked); else passed++;
        checks++; if (mode_req_ready !== 1'b0) $display("FAIL mid_ready: got %b want 0", mode_req_ready); else passed++;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        pll_lock_i = 1'b0;
        mode_req_valid = 1'b0;
        mode_req = 2'd0;
        test_reset();
        test_bringup();
        test_mode_change();
        test_glitch();
        test_req_err();
        test_fail();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pll_hdmi_reconfig.md
# pll_hdmi_reconfig

Runtime supervisor for the HDMI pixel-clock PLL (GTP_PLL_E3, 27 MHz reference, dynamic ratio ports enabled). It selects one of `NUM_MODES` video clock modes and drives the PLL's dynamic ratios. It also sequences PLL reset and output-divider reset, and qualifies lock with a debounce filter, a timeout and bounded retries. It sits between the video-timing/mode-select logic and the PLL wrapper, and runs on a free-running clock that is not derived from the PLL.

## Interface
Parameters:
- `NUM_MODES`, 3: number of entries in the mode table (package constant arrays).
- `DEFAULT_MODE`, 1: mode loaded after `rst_n` release (1 = 74.25 MHz).
- `RST_CYCLES`, 16: cycles `pll_rst_o` is held high per attempt.
- `LOCK_STABLE`, 8: consecutive synchronized-lock-high cycles required to declare lock.
- `LOCK_TIMEOUT`, 4096: cycles allowed in WAIT_LOCK per attempt.
- `MAX_RETRY`, 3: failed attempts before FAIL.
- `DIV_W`, 10: width of the ratio ports.

Ports:
- `clk` in 1: free-running system clock.
- `rst_n` in 1: reset; one clock; reset is synchronous and active-low.
- `mode_req_valid` in 1: mode change request.
- `mode_req` in `MODE_W`: requested mode index, where `MODE_W = $clog2(NUM_MODES)`.
- `mode_req_ready` out 1: request accepted when valid && ready.
- `pll_lock_i` in 1: raw PLL LOCK, asynchronous to `clk`.
- `pll_rst_o` out 1: PLL RST.
- `pll_rstodiv_o` out 1: PLL RSTODIV.
- `ratio_i_o`, `ratio_f_o`, `ratio0_o` out `DIV_W`: dynamic RATIOI/RATIOF/RATIO0.
- `cur_mode` out `MODE_W`: mode currently applied.
- `locked` out 1: qualified lock.
- `busy` out 1: reconfiguration in progress.
- `fail` out 1: retries exhausted.
- `req_err` out 1: one-cycle pulse on an out-of-range request.
- `retry_cnt` out 2: failed attempts in the current sequence.

## Operation
- States: RESET, WAIT_LOCK, LOCKED, FAIL.
- While `rst_n`=0:
  - `pll_rst_o`=1, `pll_rstodiv_o`=1.
  - Ratios and `cur_mode` take the `DEFAULT_MODE` values.
  - `locked`=0, `busy`=1, `fail`=0, `req_err`=0, `retry_cnt`=0, `mode_req_ready`=0.
  - State = RESET with the counter cleared.
- RESET:
  - `pll_rst_o`=`pll_rstodiv_o`=1 for `RST_CYCLES` cycles.
  - Ratios are stable for the whole interval.
  - Then go to WAIT_LOCK with the counter cleared.
- WAIT_LOCK:
  - Both resets are 0; the counter increments each cycle.
  - `lock_s` high for `LOCK_STABLE` consecutive cycles: go to LOCKED and clear `retry_cnt`.
  - Counter reaches `LOCK_TIMEOUT-1` without that: `retry_cnt`+1, then go to FAIL if the new value equals `MAX_RETRY`, otherwise to RESET.
- LOCKED:
  - `locked`=1.
  - A single low cycle of `lock_s` clears `locked` and goes to RESET with the same mode and `retry_cnt`=0.
- FAIL:
  - `fail`=1 and `pll_rst_o`=1 held.
  - Left only by an accepted request.
- `mode_req_ready`=1 in LOCKED and FAIL only.
- Accepted in-range request:
  - Latch `cur_mode` and the table ratios, clear `retry_cnt` and `fail`.
  - Go to RESET.
  - A request for the already-applied mode still re-runs the sequence.
- Accepted out-of-range request: pulse `req_err` for one cycle; state and outputs otherwise unchanged.
- Request in the same cycle as lock loss in LOCKED: the request wins and the new mode is loaded.
- `busy` = state is RESET or WAIT_LOCK.
- Mode table (reference clock 27 MHz, VCO 1188 MHz), RATIOI=1, RATIOF=44 for all modes:
  - Mode 0: RATIO0=44, 27 MHz.
  - Mode 1: RATIO0=16, 74.25 MHz.
  - Mode 2: RATIO0=8, 148.5 MHz.

## Timing
- `lock_s` = `pll_lock_i` through a 2-flop synchronizer, so 2 cycles of latency.
- Ratio outputs are registered and change only in the cycle that RESET is entered, while `pll_rst_o` is already 1.
- `pll_rst_o` falls exactly `RST_CYCLES` cycles after RESET entry.
- Minimum RESET entry to `locked` rise = `RST_CYCLES` + 2 + `LOCK_STABLE` cycles, when `pll_lock_i` rises at reset release.
- `locked` falls 3 cycles after `pll_lock_i` falls (2 sync + 1 state register).
- Counter width = `$clog2(max(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE))+1`. It saturates and never wraps.
- `rst_n` asserted mid-sequence: next cycle restores the reset values above, regardless of state.

## Structure
- Package `pll_hdmi_pkg`:
  - State enum.
  - `MODE_W`.
  - Mode-table constant arrays `MODE_RATIOI`/`MODE_RATIOF`/`MODE_RATIO0`, indexed by mode.
  - Reference and VCO frequency constants.
- Sub-module `pll_lock_sync`: 2-flop synchronizer plus the consecutive-high counter. It outputs `lock_s` and `lock_stable`.

## Test plan
Bench uses `RST_CYCLES`=16, `LOCK_STABLE`=8, `LOCK_TIMEOUT`=1000, `MAX_RETRY`=3.
- Release `rst_n`; drive `pll_lock_i`=1 from 20 cycles after release -> `pll_rst_o` low after 16 cycles, `ratio0_o`=16, `locked`=1 at cycle 16+4+2+8, `busy`=0.
- From LOCKED, request mode 2 -> `ratio0_o`=8 while `pll_rst_o`=1, `cur_mode`=2, `locked` re-asserts with the same latency.
- Hold `pll_lock_i`=0 -> 3 attempts of 16+1000 cycles, `retry_cnt` 1, 2, then `fail`=1, `pll_rst_o` held 1; a mode-0 request clears `fail` and restarts.
- Lock glitch: in LOCKED, drop `pll_lock_i` for 1 cycle -> `locked` falls 3 cycles later, RESET with the same mode; a lock pulse of 7 cycles in WAIT_LOCK is not accepted.
- Request `mode_req`=3 in LOCKED -> `req_err` pulses 1 cycle, `cur_mode`/`locked` unchanged; a request coincident with lock loss loads the new mode.
- Assert `rst_n`=0 during WAIT_LOCK -> next cycle all outputs at their reset values, `cur_mode`=1.
